cms_ctrl_sequencer: RTL and testbench

CMS_CTRL_SEQUENCER -- requirements
Module: cms_ctrl_sequencer

---
 rtl/cms_ctrl_sequencer.sv | 168 ++++++++++++++++
 tb/tb_cms_ctrl_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cms_ctrl_sequencer.sv
// Command FIFO plus SETUP/STROBE/GAP write sequencer for the continuous monitoring system control bus.
// Optional build macro CMS_SEQ_PAUSE_EN holds the monitoring enable low while the sequencer is busy.
module cms_ctrl_sequencer #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 64,
  parameter int FIFO_DEPTH    = 4,
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [ADDR_WIDTH-1:0]               cmd_addr,
  input  logic [DATA_WIDTH-1:0]               cmd_wdata,
  input  logic                                en_in,
  output logic [ADDR_WIDTH-1:0]               ctrl_addr,
  output logic [DATA_WIDTH-1:0]               ctrl_wdata,
  output logic                                ctrl_write_enable,
  output logic                                en,
  output logic                                busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     cmd_count,
  output logic [15:0]                         writes_done
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int PH_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [CNT_W-1:0] FULL        = CNT_W'(FIFO_DEPTH);
  localparam logic [PH_W-1:0]  STROBE_LAST = PH_W'(STROBE_CYCLES - 1);
  localparam logic [PH_W-1:0]  GAP_LAST    = PH_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

  state_t                 state_q, state_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  ctrl_addr_q, ctrl_addr_d;
  logic [DATA_WIDTH-1:0]  ctrl_wdata_q, ctrl_wdata_d;
  logic [15:0]            writes_done_q, writes_done_d;
  logic                   en_q, en_d;
  logic                   push, pop;

  logic [ADDR_WIDTH-1:0]  fifo_addr_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  fifo_wdata_q [FIFO_DEPTH];

  // Ready depends only on the stored count, so a full FIFO never accepts on a pop edge.
  assign cmd_ready         = rst_n && (count_q != FULL);
  assign push              = cmd_valid && cmd_ready;
  assign busy              = (state_q != IDLE) || (count_q != '0);
  assign ctrl_write_enable = (state_q == STROBE);
  assign ctrl_addr         = ctrl_addr_q;
  assign ctrl_wdata        = ctrl_wdata_q;
  assign cmd_count         = count_q;
  assign writes_done       = writes_done_q;
  assign en                = en_q;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    pop           = 1'b0;
    writes_done_d = writes_done_q;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = STROBE;
        phase_d = '0;
      end
      STROBE: begin
        if (phase_q == STROBE_LAST) begin
          state_d = GAP;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      GAP: begin
        if (phase_q == GAP_LAST) begin
          writes_done_d = writes_done_q + 16'd1;
          phase_d       = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl_addr_d  = ctrl_addr_q;
    ctrl_wdata_d = ctrl_wdata_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    if (pop) begin
      ctrl_addr_d  = fifo_addr_q[rd_ptr_q];
      ctrl_wdata_d = fifo_wdata_q[rd_ptr_q];
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
`ifdef CMS_SEQ_PAUSE_EN
    en_d = en_in && !busy;
`else
    en_d = en_in;
`endif
  end

  // Payload storage needs no reset: the occupancy count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q]  <= cmd_addr;
      fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      ctrl_addr_q   <= '0;
      ctrl_wdata_q  <= '0;
      writes_done_q <= '0;
      en_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      ctrl_addr_q   <= ctrl_addr_d;
      ctrl_wdata_q  <= ctrl_wdata_d;
      writes_done_q <= writes_done_d;
      en_q          <= en_d;
    end
  end

endmodule

// File: tb/tb_cms_ctrl_sequencer.sv
// Self-checking bench for cms_ctrl_sequencer: directed scenarios then random traffic against a
// queue-based timeline model. Honours CMS_SEQ_PAUSE_EN when the build defines it.
module tb_cms_ctrl_sequencer;

  localparam int AW    = 8;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int S     = 2;
  localparam int G     = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          en_in;
  logic [AW-1:0] ctrl_addr;
  logic [DW-1:0] ctrl_wdata;
  logic          ctrl_write_enable;
  logic          en;
  logic          busy;
  logic [2:0]    cmd_count;
  logic [15:0]   writes_done;

  always #5 clk = ~clk;

  cms_ctrl_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .STROBE_CYCLES(S), .GAP_CYCLES(G)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .en_in(en_in),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .ctrl_write_enable(ctrl_write_enable), .en(en), .busy(busy),
    .cmd_count(cmd_count), .writes_done(writes_done)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  // Model: a write occupies timeline slots t=0 (setup), 1..S (strobe), S+1..S+G (gap).
  cmd_t          mq[$];
  bit            m_inflight = 1'b0;
  int            m_t = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [15:0]   m_wd = '0;
  logic          m_en = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_edge();
    bit   was_busy;
    bit   was_idle;
    bit   done;
    bit   do_push;
    cmd_t c;
    was_busy = m_inflight || (mq.size() != 0);
    if (!rst_n) begin
      mq.delete();
      m_inflight = 1'b0;
      m_t = 0;
      m_addr = '0;
      m_data = '0;
      m_wd = '0;
      m_en = 1'b0;
      return;
    end
    do_push  = cmd_valid && (mq.size() < DEPTH);
    was_idle = !m_inflight;
    done     = m_inflight && (m_t == S + G);
    if (done) begin
      m_wd++;
      m_inflight = 1'b0;
    end else if (m_inflight) begin
      m_t++;
    end
    if ((was_idle || done) && mq.size() != 0) begin
      c = mq.pop_front();
      m_addr = c.a;
      m_data = c.d;
      m_inflight = 1'b1;
      m_t = 0;
    end
    if (do_push) begin
      c.a = cmd_addr;
      c.d = cmd_wdata;
      mq.push_back(c);
    end
`ifdef CMS_SEQ_PAUSE_EN
    m_en = en_in && !was_busy;
`else
    m_en = en_in;
`endif
  endfunction

  task automatic check_all();
    check("write_enable", 64'(ctrl_write_enable), 64'(m_inflight && m_t >= 1 && m_t <= S));
    check("ctrl_addr", 64'(ctrl_addr), 64'(m_addr));
    check("ctrl_wdata", ctrl_wdata, m_data);
    check("busy", 64'(busy), 64'(m_inflight || mq.size() != 0));
    check("cmd_count", 64'(cmd_count), 64'(mq.size()));
    check("cmd_ready", 64'(cmd_ready), 64'(rst_n && mq.size() < DEPTH));
    check("writes_done", 64'(writes_done), 64'(m_wd));
    check("en", 64'(en), 64'(m_en));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit taken;
    taken = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int i = 0; i < 50 && !taken; i++) begin
      taken = cmd_ready;
      step();
    end
    if (!taken) check("send_timeout", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((m_inflight || mq.size() != 0) && i < 100) begin
      step();
      i++;
    end
    if (i >= 100) check("drain_timeout", 64'(busy), 64'd0);
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    en_in     = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single command into an idle block
    en_in = 1'b1;
    send(8'h03, 64'h1234);
    drain();
    check("single_writes_done", 64'(writes_done), 64'd1);
    check("single_addr_held", 64'(ctrl_addr), 64'h03);

    // Five back-to-back commands against a four-deep FIFO
    for (int k = 0; k < 5; k++) send(8'(8'h10 + k), 64'(64'hA000 + k));
    drain();
    check("burst_writes_done", 64'(writes_done), 64'd6);

    // Push on the same edge as a GAP-exit pop with two queued
    send(8'h21, 64'h21);
    send(8'h22, 64'h22);
    send(8'h23, 64'h23);
    for (int i = 0; i < 20 && !(m_inflight && m_t == S + G && mq.size() == 2); i++) step();
    cmd_valid = 1'b1;
    cmd_addr  = 8'h24;
    cmd_wdata = 64'h24;
    step();
    cmd_valid = 1'b0;
    check("pushpop_count", 64'(cmd_count), 64'd2);
    check("pushpop_order", 64'(ctrl_addr), 64'h22);
    drain();

    // Reset during the second strobe cycle with two commands queued
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    send(8'h31, 64'h31);
    send(8'h32, 64'h32);
    send(8'h33, 64'h33);
    for (int i = 0; i < 20 && !(m_inflight && m_t == 2); i++) step();
    rst_n = 1'b0;
    step();
    check("rst_we", 64'(ctrl_write_enable), 64'd0);
    check("rst_count", 64'(cmd_count), 64'd0);
    check("rst_writes_done", 64'(writes_done), 64'd0);
    rst_n = 1'b1;
    step();

    // writes_done wrap: preload 0xFFFF, then one more write
    force dut.writes_done_q = 16'hFFFF;
    m_wd = 16'hFFFF;
    step();
    step();
    release dut.writes_done_q;
    step();
    send(8'h44, 64'hDEAD_BEEF);
    drain();
    check("wrap_writes_done", 64'(writes_done), 64'd0);

    // Random traffic with occasional reset and enable toggling
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      cmd_valid = ($urandom_range(0, 99) < 35);
      cmd_addr  = AW'($urandom);
      cmd_wdata = {$urandom, $urandom};
      en_in     = ($urandom_range(0, 9) < 7);
      step();
    end
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
